// File: rtl/pu_pkg.sv
// Shared types and defaults for the PU front-end sequencer and its result FIFO.
package pu_pkg;
  localparam int FP_W       = 32;
  localparam int PU_LAT_DEF = 3;

  typedef logic [FP_W-1:0]        fp32_t;
  typedef logic [3:0][FP_W-1:0]   vec4_t;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} drv_state_t;
endpackage

// File: rtl/pu_res_fifo.sv
// Synchronous result FIFO; head is presented combinationally and reads as zero when empty.
module pu_res_fifo
  import pu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  fp32_t                             wr_data,
  input  logic                              rd_en,
  output fp32_t                             rd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              empty,
  output logic                              full
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  fp32_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/pu_driver.sv
// PU front-end: credit-gated operand issue, latency tracker, weight-update sequencing, result FIFO.
// Optional PU_DRIVER_STATS_EN adds a 16-bit consumed-result counter port res_count.
module pu_driver
  import pu_pkg::*;
#(
  parameter int PU_LAT     = PU_LAT_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  vec4_t  in_a,
  input  logic   w_valid,
  output logic   w_ready,
  input  vec4_t  w_data,
  output fp32_t  pu_a1,
  output fp32_t  pu_a2,
  output fp32_t  pu_a3,
  output fp32_t  pu_a4,
  output vec4_t  pu_w,
  input  fp32_t  pu_out,
  output logic   res_valid,
  input  logic   res_ready,
  output fp32_t  res_data
`ifdef PU_DRIVER_STATS_EN
  ,
  output logic [15:0] res_count
`endif
);
  localparam int INF_W = $clog2(PU_LAT+1);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int SUM_W = ((INF_W > CNT_W) ? INF_W : CNT_W) + 1;

  drv_state_t        state;
  logic [PU_LAT-1:0] trk_p;
  logic [INF_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [SUM_W-1:0]  occupancy;
  logic              fifo_empty;
  logic              fifo_full;
  logic              credit;
  logic              idle_pipe;
  logic              vld_p0;
  logic              cap;
  logic              rd_take;

  // Every accepted vector owns a FIFO slot from issue until its result is read out.
  assign occupancy = SUM_W'(fifo_count) + SUM_W'(inflight);
  assign credit    = occupancy < SUM_W'(FIFO_DEPTH);
  assign idle_pipe = (inflight == '0);

  assign w_ready   = rst_n && (state == RUN) && w_valid && idle_pipe;
  assign in_ready  = rst_n && (state == RUN) && !(w_valid && idle_pipe) && credit;
  assign vld_p0    = in_valid && in_ready;
  assign cap       = trk_p[PU_LAT-1];
  assign res_valid = rst_n && !fifo_empty;
  assign rd_take   = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      trk_p    <= '0;
      inflight <= '0;
      pu_a1    <= '0;
      pu_a2    <= '0;
      pu_a3    <= '0;
      pu_a4    <= '0;
      pu_w     <= '0;
    end else begin
      trk_p <= (trk_p << 1) | PU_LAT'(vld_p0);
      case ({vld_p0, cap})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
      if (vld_p0) begin
        pu_a1 <= in_a[0];
        pu_a2 <= in_a[1];
        pu_a3 <= in_a[2];
        pu_a4 <= in_a[3];
      end
      if (w_ready) pu_w <= w_data;
      // Weights only change with the pipeline empty, so no operation sees a mix.
      case (state)
        RUN:     if (w_valid) state <= idle_pipe ? LOAD : DRAIN;
        DRAIN:   if (idle_pipe) state <= RUN;
        LOAD:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  pu_res_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap),
    .wr_data (pu_out),
    .rd_en   (rd_take),
    .rd_data (res_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(cap && fifo_full));

`ifdef PU_DRIVER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) res_count <= '0;
    else if (rd_take) res_count <= res_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_pu_driver.sv
// Bench for pu_driver: PU stub, directed vector table, queue-based reference model, weight and reset sequences.
module tb_pu_driver;
  import pu_pkg::*;

  localparam int PU_LAT     = 3;
  localparam int FIFO_DEPTH = 4;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  logic  in_ready;
  vec4_t in_a;
  logic  w_valid;
  logic  w_ready;
  vec4_t w_data;
  fp32_t pu_a1, pu_a2, pu_a3, pu_a4;
  vec4_t pu_w;
  fp32_t pu_out;
  logic  res_valid;
  logic  res_ready;
  fp32_t res_data;
`ifdef PU_DRIVER_STATS_EN
  logic [15:0] res_count;
`endif

  always #5 clk = ~clk;

  pu_driver #(.PU_LAT(PU_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .pu_a1     (pu_a1),
    .pu_a2     (pu_a2),
    .pu_a3     (pu_a3),
    .pu_a4     (pu_a4),
    .pu_w      (pu_w),
    .pu_out    (pu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
`ifdef PU_DRIVER_STATS_EN
    ,
    .res_count (res_count)
`endif
  );

  // PU stub: result on pu_out PU_LAT cycles after the accept that loaded pu_a1.
  fp32_t stub [PU_LAT-1];
  always_ff @(posedge clk) begin
    stub[0] <= pu_a1;
    for (int k = 1; k < PU_LAT-1; k++) stub[k] <= stub[k-1];
  end
  assign pu_out = stub[PU_LAT-2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [31:0] a0, input logic rr);
    in_valid  = iv;
    in_a      = {a0 + 32'd3, a0 + 32'd2, a0 + 32'd1, a0};
    res_ready = rr;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outstanding accepted vectors in order, each with its accept cycle.
  int          now;
  int          q_t[$];
  logic [31:0] q_v[$];

  task automatic model_clear();
    now = 0;
    q_t.delete();
    q_v.delete();
  endtask

  task automatic mcyc(input logic iv, input logic [31:0] a0, input logic rr,
                      input string tag, output logic acc);
    logic e_ir, e_rv;
    set_in(iv, a0, rr);
    w_valid = 1'b0;
    e_ir = (q_t.size() < FIFO_DEPTH);
    e_rv = (q_t.size() > 0) && (q_t[0] + PU_LAT + 1 <= now);
    @(negedge clk);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(e_ir));
    chk({tag, "_res_valid"}, 128'(res_valid), 128'(e_rv));
    if (e_rv) chk({tag, "_res_data"}, 128'(res_data), 128'(q_v[0]));
    if (e_rv && rr) begin
      void'(q_t.pop_front());
      void'(q_v.pop_front());
    end
    acc = iv && e_ir;
    if (acc) begin
      q_t.push_back(now);
      q_v.push_back(a0);
    end
    now++;
    next_cyc();
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] a0;
    logic        rr;
    logic        ir;
    logic        rv;
    logic [31:0] rd;
  } row_t;

  function automatic row_t mk(input logic iv, input logic [31:0] a0, input logic rr,
                              input logic ir, input logic rv, input logic [31:0] rd);
    row_t r;
    r.iv = iv; r.a0 = a0; r.rr = rr; r.ir = ir; r.rv = rv; r.rd = rd;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    row_t        tbl [23];
    logic        acc;
    vec4_t       w1;
    logic        exp_wr [7];
    logic        exp_ir [7];
    logic        exp_rv [7];
    logic [31:0] exp_rd [7];

    // Single vector (rows 0-5), then back-pressure with 8 offers (rows 6-22).
    tbl[0]  = mk(1, 32'h3F800000, 1, 1, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 1, 0, 0);
    tbl[4]  = mk(0, 0, 1, 1, 1, 32'h3F800000);
    tbl[5]  = mk(0, 0, 1, 1, 0, 0);
    tbl[6]  = mk(1, 32'h100, 0, 1, 0, 0);
    tbl[7]  = mk(1, 32'h101, 0, 1, 0, 0);
    tbl[8]  = mk(1, 32'h102, 0, 1, 0, 0);
    tbl[9]  = mk(1, 32'h103, 0, 1, 0, 0);
    tbl[10] = mk(1, 32'h104, 0, 0, 1, 32'h100);
    tbl[11] = mk(1, 32'h104, 0, 0, 1, 32'h100);
    tbl[12] = mk(1, 32'h104, 0, 0, 1, 32'h100);
    tbl[13] = mk(1, 32'h104, 1, 0, 1, 32'h100);
    tbl[14] = mk(1, 32'h104, 1, 1, 1, 32'h101);
    tbl[15] = mk(1, 32'h105, 1, 1, 1, 32'h102);
    tbl[16] = mk(1, 32'h106, 1, 1, 1, 32'h103);
    tbl[17] = mk(1, 32'h107, 1, 1, 0, 0);
    tbl[18] = mk(0, 0, 1, 0, 1, 32'h104);
    tbl[19] = mk(0, 0, 1, 1, 1, 32'h105);
    tbl[20] = mk(0, 0, 1, 1, 1, 32'h106);
    tbl[21] = mk(0, 0, 1, 1, 1, 32'h107);
    tbl[22] = mk(0, 0, 1, 1, 0, 0);

    // Reset with both requests offered: outputs must stay quiet.
    rst_n = 1'b0;
    set_in(1'b1, 32'hDEAD0000, 1'b0);
    w_valid = 1'b1;
    w_data  = {32'h1, 32'h2, 32'h3, 32'h4};
    repeat (2) next_cyc();
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_w_ready", 128'(w_ready), 128'(0));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_pu_a1", 128'(pu_a1), 128'(0));
    chk("rst_pu_a4", 128'(pu_a4), 128'(0));
    chk("rst_pu_w", 128'(pu_w), 128'(0));
    chk("rst_res_data", 128'(res_data), 128'(0));
    next_cyc();
    rst_n = 1'b1;
    w_valid = 1'b0;

    for (int i = 0; i < 23; i++) begin
      set_in(tbl[i].iv, tbl[i].a0, tbl[i].rr);
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].ir));
      chk($sformatf("tbl%0d_res_valid", i), 128'(res_valid), 128'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("tbl%0d_res_data", i), 128'(res_data), 128'(tbl[i].rd));
      next_cyc();
    end

    // Streaming: each vector held until accepted, results tracked by the model.
    model_clear();
    for (int k = 0; k < 16; k++) begin
      acc = 1'b0;
      for (int g = 0; g < 8 && !acc; g++) mcyc(1'b1, 32'h200 + k, 1'b1, "stream", acc);
    end
    repeat (8) mcyc(1'b0, 32'h0, 1'b1, "stream_drain", acc);

    // Randomized traffic.
    for (int k = 0; k < 300; k++)
      mcyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0), "rand", acc);
    repeat (10) mcyc(1'b0, 32'h0, 1'b1, "rand_drain", acc);

    // Reset with three operations in flight.
    for (int k = 0; k < 3; k++) mcyc(1'b1, 32'h300 + k, 1'b1, "pre_rst", acc);
    rst_n = 1'b0;
    set_in(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    next_cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) chk("postrst_in_ready", 128'(in_ready), 128'(1));
      chk($sformatf("postrst%0d_res_valid", k), 128'(res_valid), 128'(0));
      next_cyc();
    end

    // Weight update with two operations in flight.
    w1 = {32'h40400000, 32'h40000000, 32'h3F800000, 32'h3F000000};
    set_in(1'b1, 32'hA0, 1'b1);
    next_cyc();
    set_in(1'b1, 32'hA1, 1'b1);
    next_cyc();
    exp_wr = '{0, 0, 0, 0, 1, 0, 0};
    exp_ir = '{1, 0, 0, 0, 0, 0, 1};
    exp_rv = '{0, 0, 1, 1, 0, 0, 0};
    exp_rd = '{0, 0, 32'hA0, 32'hA1, 0, 0, 0};
    for (int k = 0; k < 7; k++) begin
      set_in(1'b0, 32'h0, 1'b1);
      w_valid = (k <= 4);
      w_data  = w1;
      @(negedge clk);
      if (k == 0) begin
        chk("wt_pu_a1", 128'(pu_a1), 128'(32'hA1));
        chk("wt_pu_a4", 128'(pu_a4), 128'(32'hA4));
      end
      chk($sformatf("wt%0d_w_ready", k), 128'(w_ready), 128'(exp_wr[k]));
      chk($sformatf("wt%0d_in_ready", k), 128'(in_ready), 128'(exp_ir[k]));
      chk($sformatf("wt%0d_res_valid", k), 128'(res_valid), 128'(exp_rv[k]));
      if (exp_rv[k]) chk($sformatf("wt%0d_res_data", k), 128'(res_data), 128'(exp_rd[k]));
      chk($sformatf("wt%0d_pu_w", k), 128'(pu_w), (k >= 5) ? 128'(w1) : 128'(0));
      next_cyc();
    end
    w_valid = 1'b0;

    // Consumed-result counting from a fresh reset.
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    model_clear();
`ifdef PU_DRIVER_STATS_EN
    @(negedge clk);
    chk("stats_reset", 128'(res_count), 128'(0));
    next_cyc();
    now = 1;
`endif
    for (int k = 0; k < 5; k++) mcyc(1'b1, 32'h500 + k, 1'b1, "stats", acc);
    repeat (10) mcyc(1'b0, 32'h0, 1'b1, "stats_drain", acc);
`ifdef PU_DRIVER_STATS_EN
    @(negedge clk);
    chk("stats_count", 128'(res_count), 128'(5));
    next_cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
